alu_issue_ctrl: RTL and testbench
=================================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with the ports listed below.
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- instr_valid  in  1  instruction offered
- instr_data  in  16  instruction word
- instr_ready  out  1  block can accept an instruction
- alu_x  out  16  ALU operand x
- alu_y  out  16  ALU operand y
- alu_c  out  3  ALU control code
- alu_z  in  16  ALU result
- alu_lt, alu_eq, alu_gt, alu_ovf, alu_cout  in  1 each  ALU flags
- res_valid  out  1  result pulse
- res_data  out  16  value written to rd
- res_flags  out  5  {lt,eq,gt,ovf,cout} captured from the ALU
- res_err  out  1  illegal opcode flag, qualified by res_valid
- ovf_sticky  out  1  sticky overflow (present only under ALU_ISSUE_OVF_STICKY_EN)

Function
REQ-002 Instruction fields SHALL be: [15:13] op, [12:11] rd, [10:9] rs, [8:7] rt, [6:0] ignored.
REQ-003 op 000/001/010/011/111 SHALL be AND/OR/ADD/SUB/SLT and SHALL be passed unchanged to alu_c.
REQ-004 op 100 SHALL be LOADI: rd <= {5'b0, instr[10:0]}; the ALU is not used.
REQ-005 op 101 and 110 SHALL be illegal.
REQ-006 The block SHALL contain an internal 4x16 register file r0..r3.
REQ-007 The FSM SHALL have three states, IDLE -> ISSUE -> DONE -> IDLE.
REQ-008 instr_ready SHALL be 1 only in IDLE.
REQ-009 An instruction SHALL be accepted on an edge where instr_valid=1 and instr_ready=1; the block SHALL latch it and enter ISSUE.
REQ-010 In ISSUE, for ALU ops, the block SHALL drive alu_x=r[rs], alu_y=r[rt] and alu_c=op.
REQ-011 In all other states and for non-ALU ops, alu_x, alu_y and alu_c SHALL be 0.
REQ-012 On the edge ending ISSUE, the block SHALL capture alu_z and the flags into res_data/res_flags, write r[rd] and enter DONE.
REQ-013 LOADI SHALL write the immediate to rd and res_data, with res_flags=0.
REQ-014 An illegal op SHALL set res_err=1, SHALL NOT write the register file, and SHALL set res_data=0 and res_flags=0.
REQ-015 In DONE, res_valid SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-016 Latency SHALL be: res_valid high in the 2nd cycle after the accepting edge; throughput one instruction per 3 cycles.
REQ-017 res_data, res_flags and res_err SHALL hold their values until the next DONE.
REQ-018 instr_data SHALL be ignored when instr_ready=0; instr_valid held high across DONE SHALL be accepted in the following IDLE cycle.
REQ-019 When rd equals rs or rt, the read SHALL return the old value, and the write SHALL take effect at the capture edge.

Reset
REQ-020 While rst_n=0 at an edge, the block SHALL force state=IDLE, r0..r3=0, res_data=0, res_flags=0, res_err=0, res_valid=0 and ovf_sticky=0.
REQ-021 Reset in ISSUE or DONE SHALL abort the instruction, with no register write and no res_valid pulse.
REQ-022 After release of reset, instr_ready SHALL be 1 in the first cycle.

Configuration
REQ-023 With ALU_ISSUE_OVF_STICKY_EN defined, ovf_sticky SHALL be set at the capture edge of any ADD/SUB with alu_ovf=1, and SHALL be cleared only by reset.
REQ-024 Without ALU_ISSUE_OVF_STICKY_EN, the ovf_sticky port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- LOADI r1=11, LOADI r2=19, AND r0=r1&r2 -> res_data=0x0003; r0=3; res_valid exactly 2 cycles after each accept.
- OR r3=r2|r1 -> 0x001B; ADD r3=r2+r1 -> 0x001E; SUB r3=r1-r2 -> 0xFFF8 with res_flags lt=1.
- SLT r0=r1,r2 -> 0x0001; SLT r0=r2,r1 -> 0x0000.
- LOADI r1=0x400, then ADD r1=r1+r1 five times -> r1=0x8000; alu_ovf captured 1 on the 5th ADD; ovf_sticky=1 under the macro.
- op 101 -> res_err=1, res_data=0, r0..r3 unchanged; the next legal instruction -> res_err=0.
- rst_n=0 for one edge during ISSUE of ADD r2 -> no res_valid pulse, r2=0, instr_ready=1 on the next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle for alu_issue_ctrl: instruction handshake, ALU operand/result
// lanes and the result report. The slave modport is the controller's view;
// the master modport is the view of whatever feeds instructions and hosts
// the ALU.
interface alu_issue_ctrl_if;
   logic        instr_valid;
   logic [15:0] instr_data;
   logic        instr_ready;
   logic [15:0] alu_x;
   logic [15:0] alu_y;
   logic [2:0]  alu_c;
   logic [15:0] alu_z;
   logic        alu_lt;
   logic        alu_eq;
   logic        alu_gt;
   logic        alu_ovf;
   logic        alu_cout;
   logic        res_valid;
   logic [15:0] res_data;
   logic [4:0]  res_flags;
   logic        res_err;

   modport slave (
      input  instr_valid, instr_data,
      output instr_ready,
      output alu_x, alu_y, alu_c,
      input  alu_z, alu_lt, alu_eq, alu_gt, alu_ovf, alu_cout,
      output res_valid, res_data, res_flags, res_err
   );

   modport master (
      output instr_valid, instr_data,
      input  instr_ready,
      input  alu_x, alu_y, alu_c,
      output alu_z, alu_lt, alu_eq, alu_gt, alu_ovf, alu_cout,
      input  res_valid, res_data, res_flags, res_err
   );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts one 16-bit instruction at a time, issues it to an
// external ALU (or handles LOADI / illegal ops locally), writes the 4x16
// register file and reports the result with a one-cycle res_valid pulse.
// Sequence per instruction: IDLE (accept) -> ISSUE (ALU driven, capture on
// exit) -> DONE (res_valid) -> IDLE.
// Optional feature: define ALU_ISSUE_OVF_STICKY_EN to add the ovf_sticky
// output, set by any ADD/SUB whose captured alu_ovf is 1, cleared by reset.
module alu_issue_ctrl (
   input  logic clk,
   input  logic rst_n,
`ifdef ALU_ISSUE_OVF_STICKY_EN
   output logic ovf_sticky,
`endif
   alu_issue_ctrl_if.slave bus
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SUB   = 3'b011;
   localparam logic [2:0] OP_LOADI = 3'b100;

   logic [1:0]       state_reg;
   logic [1:0]       state_next;
   logic [15:0]      instr_reg;
   logic [3:0][15:0] rf_q;

   logic [15:0] res_data_reg;
   logic [4:0]  res_flags_reg;
   logic        res_err_reg;
   logic        res_valid_reg;

   logic        accept;
   logic [2:0]  op;
   logic [1:0]  rd;
   logic [1:0]  rs;
   logic [1:0]  rt;
   logic [15:0] imm;
   logic        is_alu;
   logic        is_loadi;
   logic        capture;
   logic        wr_en;
   logic [15:0] wr_data;

   assign op  = instr_reg[15:13];
   assign rd  = instr_reg[12:11];
   assign rs  = instr_reg[10:9];
   assign rt  = instr_reg[8:7];
   assign imm = {5'b0, instr_reg[10:0]};

   // AND/OR/ADD/SUB/SLT go to the ALU; 101 and 110 are neither class.
   assign is_alu   = (op == 3'b000) || (op == 3'b001) || (op == OP_ADD) ||
                     (op == OP_SUB) || (op == 3'b111);
   assign is_loadi = (op == OP_LOADI);

   assign bus.instr_ready = (state_reg == ST_IDLE);
   assign accept          = bus.instr_valid && (state_reg == ST_IDLE);
   assign capture         = (state_reg == ST_ISSUE);

   // Writes land on the edge that leaves ISSUE, so same-register reads in
   // ISSUE still see the old value.
   assign wr_en   = capture && (is_alu || is_loadi);
   assign wr_data = is_alu ? bus.alu_z : imm;

   assign bus.res_valid = res_valid_reg;
   assign bus.res_data  = res_data_reg;
   assign bus.res_flags = res_flags_reg;
   assign bus.res_err   = res_err_reg;

   // Next-state logic for the three-phase issue sequence.
   always_comb begin
      state_next = ST_IDLE;
      case (state_reg)
         ST_IDLE:  state_next = accept ? ST_ISSUE : ST_IDLE;
         ST_ISSUE: state_next = ST_DONE;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // State register; reset anywhere aborts the instruction in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) state_reg <= ST_IDLE;
      else        state_reg <= state_next;
   end

   // Latch the instruction only on an accepting edge; instr_data is ignored otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n)      instr_reg <= '0;
      else if (accept) instr_reg <= bus.instr_data;
   end

   // Drive ALU operands only while issuing an ALU op; zero otherwise.
   always_comb begin
      bus.alu_x = '0;
      bus.alu_y = '0;
      bus.alu_c = '0;
      if (capture && is_alu) begin
         bus.alu_x = rf_q[rs];
         bus.alu_y = rf_q[rt];
         bus.alu_c = op;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rf
         logic [15:0] r_reg;
         // One register-file entry, written at the capture edge when selected by rd.
         always_ff @(posedge clk) begin
            if (!rst_n)
               r_reg <= '0;
            else if (wr_en && (rd == gi[1:0]))
               r_reg <= wr_data;
         end
         assign rf_q[gi] = r_reg;
      end
   endgenerate

   // Result report: captured when leaving ISSUE, held until the next capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid_reg <= 1'b0;
         res_data_reg  <= '0;
         res_flags_reg <= '0;
         res_err_reg   <= 1'b0;
      end else begin
         res_valid_reg <= capture;
         if (capture) begin
            if (is_alu) begin
               res_data_reg  <= bus.alu_z;
               res_flags_reg <= {bus.alu_lt, bus.alu_eq, bus.alu_gt,
                                 bus.alu_ovf, bus.alu_cout};
               res_err_reg   <= 1'b0;
            end else if (is_loadi) begin
               res_data_reg  <= imm;
               res_flags_reg <= '0;
               res_err_reg   <= 1'b0;
            end else begin
               res_data_reg  <= '0;
               res_flags_reg <= '0;
               res_err_reg   <= 1'b1;
            end
         end
      end
   end

`ifdef ALU_ISSUE_OVF_STICKY_EN
   logic ovf_sticky_reg;

   // Sticky overflow: any ADD/SUB overflow since the last reset.
   always_ff @(posedge clk) begin
      if (!rst_n)
         ovf_sticky_reg <= 1'b0;
      else if (capture && ((op == OP_ADD) || (op == OP_SUB)) && bus.alu_ovf)
         ovf_sticky_reg <= 1'b1;
   end

   assign ovf_sticky = ovf_sticky_reg;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: hosts a behavioural ALU, keeps a reference
// register file, runs the directed scenarios then random instructions.
module tb_alu_issue_ctrl;

   logic clk;
   logic rst_n;
`ifdef ALU_ISSUE_OVF_STICKY_EN
   logic ovf_sticky;
`endif

   alu_issue_ctrl_if bus ();

   alu_issue_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
`ifdef ALU_ISSUE_OVF_STICKY_EN
      .ovf_sticky (ovf_sticky),
`endif
      .bus        (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests  = 0;
   int failed = 0;

   // reference state
   logic [15:0] ref_rf [4];
   logic [15:0] ref_data;
   logic [4:0]  ref_flags;
   logic        ref_err;
   logic        ref_sticky;

   // Behavioural ALU: returns {z, lt, eq, gt, ovf, cout}
   function automatic logic [20:0] alu_fn(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
      int ux, uy, sx, sy, r, sr;
      logic [15:0] z;
      logic lt, eq, gt, ovf, cout;
      ux = x; uy = y; sx = $signed(x); sy = $signed(y);
      lt = sx < sy; eq = (ux == uy); gt = sx > sy;
      ovf = 1'b0; cout = 1'b0; z = '0;
      case (c)
         3'b000: z = x & y;
         3'b001: z = x | y;
         3'b010: begin
            r = ux + uy; sr = sx + sy;
            z = r[15:0]; cout = (r > 65535);
            ovf = (sr > 32767) || (sr < -32768);
         end
         3'b011: begin
            r = ux - uy; sr = sx - sy;
            z = r[15:0]; cout = (ux >= uy);
            ovf = (sr > 32767) || (sr < -32768);
         end
         3'b111: z = lt ? 16'd1 : 16'd0;
         default: z = '0;
      endcase
      return {z, lt, eq, gt, ovf, cout};
   endfunction

   always_comb begin
      {bus.alu_z, bus.alu_lt, bus.alu_eq, bus.alu_gt, bus.alu_ovf, bus.alu_cout} =
         alu_fn(bus.alu_c, bus.alu_x, bus.alu_y);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] enc(input logic [2:0] op, input int rd, input int rs, input int rt);
      logic [1:0] a, b, c;
      a = rd[1:0]; b = rs[1:0]; c = rt[1:0];
      return {op, a, b, c, 7'b0};
   endfunction

   function automatic logic [15:0] ldi(input int rd, input logic [10:0] v);
      logic [1:0] a;
      a = rd[1:0];
      return {3'b100, a, v};
   endfunction

   // Run one instruction from an IDLE negedge through DONE and back to IDLE.
   task automatic exec(input logic [15:0] ins);
      logic [2:0] op;
      int rd, rs, rt, n;
      bit alu_op;
      logic [20:0] res;
      op = ins[15:13]; rd = ins[12:11]; rs = ins[10:9]; rt = ins[8:7];
      alu_op = (op != 3'b100) && (op != 3'b101) && (op != 3'b110);
      n = 0;
      while (bus.instr_ready !== 1'b1 && n < 8) begin @(negedge clk); n++; end
      check("ready_idle", bus.instr_ready, 1);
      bus.instr_valid = 1'b1; bus.instr_data = ins;
      @(negedge clk);
      // ISSUE cycle; junk offered while not ready must be ignored
      bus.instr_data = 16'($urandom);
      check("issue_ready", bus.instr_ready, 0);
      check("issue_valid", bus.res_valid, 0);
      check("alu_x", bus.alu_x, alu_op ? ref_rf[rs] : 16'h0);
      check("alu_y", bus.alu_y, alu_op ? ref_rf[rt] : 16'h0);
      check("alu_c", bus.alu_c, alu_op ? op : 3'h0);
      // reference outcome
      if (alu_op) begin
         res = alu_fn(op, ref_rf[rs], ref_rf[rt]);
         ref_data = res[20:5]; ref_flags = res[4:0]; ref_err = 1'b0;
         ref_rf[rd] = res[20:5];
         if ((op == 3'b010 || op == 3'b011) && res[1]) ref_sticky = 1'b1;
      end else if (op == 3'b100) begin
         ref_data = {5'b0, ins[10:0]}; ref_flags = '0; ref_err = 1'b0;
         ref_rf[rd] = ref_data;
      end else begin
         ref_data = '0; ref_flags = '0; ref_err = 1'b1;
      end
      @(negedge clk);
      bus.instr_data = 16'($urandom);
      check("done_valid", bus.res_valid, 1);
      check("res_data", bus.res_data, ref_data);
      check("res_flags", bus.res_flags, ref_flags);
      check("res_err", bus.res_err, ref_err);
      check("done_alu_x", bus.alu_x, 0);
`ifdef ALU_ISSUE_OVF_STICKY_EN
      check("ovf_sticky", ovf_sticky, ref_sticky);
`endif
      @(negedge clk);
      check("idle_valid", bus.res_valid, 0);
      check("idle_ready", bus.instr_ready, 1);
      check("hold_data", bus.res_data, ref_data);
      bus.instr_valid = 1'b0;
   endtask

   // Observe every register through alu_x by rewriting it with itself.
   task automatic check_regs();
      for (int k = 0; k < 4; k++) exec(enc(3'b001, k, k, k));
   endtask

   task automatic ref_reset();
      for (int k = 0; k < 4; k++) ref_rf[k] = '0;
      ref_data = '0; ref_flags = '0; ref_err = 1'b0; ref_sticky = 1'b0;
   endtask

   initial begin
      ref_reset();
      rst_n = 1'b0; bus.instr_valid = 1'b0; bus.instr_data = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_ready", bus.instr_ready, 1);
      check("rst_valid", bus.res_valid, 0);
      check("rst_data", bus.res_data, 0);
      check("rst_flags", bus.res_flags, 0);
      check("rst_err", bus.res_err, 0);
`ifdef ALU_ISSUE_OVF_STICKY_EN
      check("rst_sticky", ovf_sticky, 0);
`endif

      // LOADI / AND
      exec(ldi(1, 11'd11));
      check("ldi_r1", bus.res_data, 16'd11);
      exec(ldi(2, 11'd19));
      exec(enc(3'b000, 0, 1, 2));
      check("and_res", bus.res_data, 16'h0003);
      // OR / ADD / SUB
      exec(enc(3'b001, 3, 2, 1));
      check("or_res", bus.res_data, 16'h001B);
      exec(enc(3'b010, 3, 2, 1));
      check("add_res", bus.res_data, 16'h001E);
      exec(enc(3'b011, 3, 1, 2));
      check("sub_res", bus.res_data, 16'hFFF8);
      check("sub_lt", bus.res_flags[4], 1);
      // SLT
      exec(enc(3'b111, 0, 1, 2));
      check("slt_1", bus.res_data, 16'h0001);
      exec(enc(3'b111, 0, 2, 1));
      check("slt_0", bus.res_data, 16'h0000);
      // overflow chain
      exec(ldi(1, 11'h400));
      for (int i = 0; i < 5; i++) exec(enc(3'b010, 1, 1, 1));
      check("ovf_data", bus.res_data, 16'h8000);
      check("ovf_flag", bus.res_flags[1], 1);
`ifdef ALU_ISSUE_OVF_STICKY_EN
      check("ovf_sticky_set", ovf_sticky, 1);
`endif
      // illegal op
      exec(enc(3'b101, 0, 1, 2));
      check("ill_err", bus.res_err, 1);
      check("ill_data", bus.res_data, 0);
      check_regs();
      check("ill_clear", bus.res_err, 0);
      exec(enc(3'b110, 2, 3, 0));
      check("ill110_err", bus.res_err, 1);

      // reset during ISSUE of ADD r2
      bus.instr_valid = 1'b1; bus.instr_data = enc(3'b010, 2, 1, 1);
      @(negedge clk);
      check("abort_issue", bus.instr_ready, 0);
      bus.instr_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ref_reset();
      check("abort_valid", bus.res_valid, 0);
      check("abort_ready", bus.instr_ready, 1);
      check("abort_data", bus.res_data, 0);
      @(negedge clk);
      check("abort_valid2", bus.res_valid, 0);
`ifdef ALU_ISSUE_OVF_STICKY_EN
      check("abort_sticky", ovf_sticky, 0);
`endif
      check_regs();

      // random instructions against the reference model
      for (int i = 0; i < 60; i++) exec(16'($urandom));
      check_regs();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // global timeout
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
